palette_mapper: RTL and testbench

Parametrised pixel-to-RGB mapper for the VGA output path, between the frame-buffer read pipeline and the VGA DAC pins. Each pixel is mapped in one of two modes. Direct mode expands packed R/G/B fields to OUT_W bits per channel by bit replication. Palette mode looks the pixel up in a CPU-writable palette RAM. The block is a fixed 2-cycle pipeline, runs a self-initialising palette fill after reset, and provides a valid/ready palette write port.

---
 rtl/palette_mapper.sv | 252 +++++++++++++++++++++++++
 tb/tb_palette_mapper.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : palette_mapper
//  Function : Pixel-to-RGB mapper for the VGA output path. Each pixel is
//             expanded in direct mode (per-field bit replication) or looked
//             up in a CPU-writable palette RAM. The block is a fixed 2-stage
//             pipeline. After reset it fills the palette with the direct
//             expansion of every index, one entry per cycle.
//  Options  : `define PALETTE_BLANK_WRITE_EN to accept palette writes only
//             while pix_blank is high (avoids mid-line tearing).
//  Revision : 1.0 - initial release
// ============================================================================
module palette_mapper #(
  parameter int RBITS = 3,
  parameter int GBITS = 3,
  parameter int BBITS = 2,
  parameter int OUT_W = 8,
  parameter int PIX_W = RBITS + GBITS + BBITS
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [PIX_W-1:0]     pixel,
  input  logic                 pix_valid,
  input  logic                 pix_blank,
  input  logic                 mode,
  output logic [OUT_W-1:0]     Red,
  output logic [OUT_W-1:0]     Green,
  output logic [OUT_W-1:0]     Blue,
  output logic                 out_valid,
  input  logic                 pal_wr_valid,
  output logic                 pal_wr_ready,
  input  logic [PIX_W-1:0]     pal_wr_addr,
  input  logic [3*OUT_W-1:0]   pal_wr_data,
  output logic                 init_busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int C_DEPTH = 1 << PIX_W;
  localparam int C_RGB_W = 3 * OUT_W;

  // Number of field copies needed to cover OUT_W bits, and how many surplus
  // low bits fall off when the replicated vector is truncated to OUT_W.
  localparam int C_R_REP = (OUT_W + RBITS - 1) / RBITS;
  localparam int C_G_REP = (OUT_W + GBITS - 1) / GBITS;
  localparam int C_B_REP = (OUT_W + BBITS - 1) / BBITS;
  localparam int C_R_SH  = C_R_REP * RBITS - OUT_W;
  localparam int C_G_SH  = C_G_REP * GBITS - OUT_W;
  localparam int C_B_SH  = C_B_REP * BBITS - OUT_W;

  localparam logic [PIX_W-1:0] C_LAST_IDX = {PIX_W{1'b1}};

  localparam logic [0:0] C_ST_INIT = 1'b0;
  localparam logic [0:0] C_ST_RUN  = 1'b1;

  // --------------------------------------------------------------------------
  // Direct expansion: each field is repeated MSB-first until OUT_W bits are
  // filled, then the excess LSBs are dropped. This maps code 0 to all-zeros
  // and the max code to all-ones, with evenly spread steps in between.
  // --------------------------------------------------------------------------
  function automatic logic [C_RGB_W-1:0] map_direct(input logic [PIX_W-1:0] p);
    logic [C_R_REP*RBITS-1:0] r_rep;
    logic [C_G_REP*GBITS-1:0] g_rep;
    logic [C_B_REP*BBITS-1:0] b_rep;
    logic [OUT_W-1:0]         r_out;
    logic [OUT_W-1:0]         g_out;
    logic [OUT_W-1:0]         b_out;
    r_rep = {C_R_REP{p[PIX_W-1 -: RBITS]}};
    g_rep = {C_G_REP{p[BBITS +: GBITS]}};
    b_rep = {C_B_REP{p[BBITS-1:0]}};
    r_out = OUT_W'(r_rep >> C_R_SH);
    g_out = OUT_W'(g_rep >> C_G_SH);
    b_out = OUT_W'(b_rep >> C_B_SH);
    return {r_out, g_out, b_out};
  endfunction

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  // Init FSM
  logic [0:0]          state_q, state_d;
  logic [PIX_W-1:0]    cnt_q, cnt_d;
  logic                fill_en;

  // Palette RAM and its write port
  logic [C_RGB_W-1:0]  pal_mem_q [0:C_DEPTH-1];
  logic                mem_we;
  logic [PIX_W-1:0]    mem_waddr;
  logic [C_RGB_W-1:0]  mem_wdata;

  // Stage 1
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic                mode_q, mode_d;
  logic                blank_q, blank_d;
  logic                valid_q, valid_d;
  logic [C_RGB_W-1:0]  rd_data_q, rd_data_d;

  // Stage 2
  logic [C_RGB_W-1:0]  rgb_sel;
  logic [OUT_W-1:0]    red_q, red_d;
  logic [OUT_W-1:0]    green_q, green_d;
  logic [OUT_W-1:0]    blue_q, blue_d;
  logic                out_valid_q, out_valid_d;

  // --------------------------------------------------------------------------
  // Init FSM
  // --------------------------------------------------------------------------
  // State register: reset always restarts the fill from entry 0.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= C_ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk every palette index once, then settle in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      C_ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_IDX) begin
          state_d = C_ST_RUN;
        end
      end
      C_ST_RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = C_ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: the fill owns the RAM write port during INIT; the user port
  // is only opened in RUN, and never while reset is asserted.
  always_comb begin
    init_busy    = (state_q == C_ST_INIT);
    fill_en      = 1'b0;
    pal_wr_ready = 1'b0;
    if (state_q == C_ST_INIT) begin
      fill_en = Reset_n;
    end else if (Reset_n) begin
`ifdef PALETTE_BLANK_WRITE_EN
      pal_wr_ready = pix_blank;
`else
      pal_wr_ready = 1'b1;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Palette RAM
  // --------------------------------------------------------------------------
  // Write-port mux: fill entries take priority; user writes land on handshake.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = map_direct(cnt_q);
    if (fill_en) begin
      mem_we = 1'b1;
    end else if (pal_wr_valid && pal_wr_ready) begin
      mem_we    = 1'b1;
      mem_waddr = pal_wr_addr;
      mem_wdata = pal_wr_data;
    end
  end

  // RAM storage: contents are not reset; the post-reset fill defines them.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      pal_mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: capture the pixel and launch the palette read. The read uses the
  // pre-edge RAM contents, so a same-cycle write to the same index is seen
  // only by the next lookup (read-first).
  // --------------------------------------------------------------------------
  // Stage-1 next values; palette mode is suppressed while the fill is active.
  always_comb begin
    pix_d     = pixel;
    mode_d    = mode & ~init_busy;
    blank_d   = pix_blank;
    valid_d   = pix_valid;
    rd_data_d = pal_mem_q[pixel];
  end

  // Stage-1 registers, cleared on reset to discard in-flight pixels.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pix_q     <= '0;
      mode_q    <= 1'b0;
      blank_q   <= 1'b0;
      valid_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      pix_q     <= pix_d;
      mode_q    <= mode_d;
      blank_q   <= blank_d;
      valid_q   <= valid_d;
      rd_data_q <= rd_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: pick the colour source per pixel and register the outputs.
  // --------------------------------------------------------------------------
  // Colour select: blanking overrides both modes.
  always_comb begin
    rgb_sel = map_direct(pix_q);
    if (mode_q) begin
      rgb_sel = rd_data_q;
    end
    if (blank_q) begin
      rgb_sel = '0;
    end
    red_d       = rgb_sel[C_RGB_W-1 -: OUT_W];
    green_d     = rgb_sel[2*OUT_W-1 -: OUT_W];
    blue_d      = rgb_sel[OUT_W-1:0];
    out_valid_d = valid_q;
  end

  // Output registers feeding the DAC pins.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Red       = red_q;
  assign Green     = green_q;
  assign Blue      = blue_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_palette_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_palette_mapper
//  Function : Self-checking bench for palette_mapper (default parameters).
//             Stimulus pushes expected colours into a scoreboard queue; a
//             monitor pops and compares whenever out_valid is high, and also
//             checks the 2-cycle latency. Builds with or without
//             PALETTE_BLANK_WRITE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_palette_mapper;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [7:0]  pixel;
  logic        pix_valid;
  logic        pix_blank;
  logic        mode;
  logic [7:0]  Red, Green, Blue;
  logic        out_valid;
  logic        pal_wr_valid;
  logic        pal_wr_ready;
  logic [7:0]  pal_wr_addr;
  logic [23:0] pal_wr_data;
  logic        init_busy;

  palette_mapper dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .pixel        (pixel),
    .pix_valid    (pix_valid),
    .pix_blank    (pix_blank),
    .mode         (mode),
    .Red          (Red),
    .Green        (Green),
    .Blue         (Blue),
    .out_valid    (out_valid),
    .pal_wr_valid (pal_wr_valid),
    .pal_wr_ready (pal_wr_ready),
    .pal_wr_addr  (pal_wr_addr),
    .pal_wr_data  (pal_wr_data),
    .init_busy    (init_busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [23:0] rgb;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Expected direct-mode colour, written as closed-form arithmetic.
  function automatic logic [7:0] x3(input int v);
    return 8'((v << 5) | (v << 2) | (v >> 1));
  endfunction
  function automatic logic [7:0] x2(input int v);
    return 8'(v * 85);
  endfunction
  function automatic logic [23:0] direct(input logic [7:0] p);
    return {x3(int'(p[7:5])), x3(int'(p[4:2])), x2(int'(p[1:0]))};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    pixel     = 8'h00;
    pix_valid = 1'b0;
    pix_blank = 1'b0;
    mode      = 1'b0;
  endtask

  task automatic put_pix(input logic [7:0] p, input logic m, input logic b,
                         input logic [23:0] exp, input string tag);
    pixel     = p;
    mode      = m;
    pix_blank = b;
    pix_valid = 1'b1;
    sb.push_back('{rgb: exp, cyc: cyc, tag: tag});
  endtask

  // Palette write issued during a blank, non-valid cycle (accepted in both builds).
  task automatic pal_write(input logic [7:0] a, input logic [23:0] d);
    idle();
    pix_blank    = 1'b1;
    pal_wr_valid = 1'b1;
    pal_wr_addr  = a;
    pal_wr_data  = d;
    #1;
    chk("wr_ready_on_write", 32'(pal_wr_ready), 32'd1);
    tick();
    pal_wr_valid = 1'b0;
    pix_blank    = 1'b0;
  endtask

  // Counts INIT cycles from the current point and checks ready stays low.
  task automatic wait_init(input string tag, output int n);
    int bad;
    n   = 0;
    bad = 0;
    while (init_busy === 1'b1 && n < 1000) begin
      if (pal_wr_ready !== 1'b0) bad++;
      n++;
      tick();
    end
    chk({tag, "_init_cycles"}, 32'(n), 32'd256);
    chk({tag, "_ready_low_in_init"}, 32'(bad), 32'd0);
  endtask

  // Monitor: every valid output must match the oldest expectation, 2 cycles on.
  always @(negedge Clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got rgb=0x%06h with empty scoreboard", {Red, Green, Blue});
      end else begin
        mon_e = sb.pop_front();
        if ({Red, Green, Blue} !== mon_e.rgb || (cyc - mon_e.cyc) != 2) begin
          failures++;
          $display("FAIL %s: got rgb=0x%06h latency=%0d expected rgb=0x%06h latency=2",
                   mon_e.tag, {Red, Green, Blue}, cyc - mon_e.cyc, mon_e.rgb);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    idle();
    Reset_n      = 1'b0;
    pal_wr_valid = 1'b0;
    pal_wr_addr  = 8'h00;
    pal_wr_data  = 24'h0;

    // Reset for 2 cycles
    tick();
    tick();
    chk("rst_rgb", 32'({Red, Green, Blue}), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_wr_ready", 32'(pal_wr_ready), 32'd0);
    Reset_n = 1'b1;

    // First INIT: a palette-mode pixel here must come out as direct expansion.
    n = 0;
    begin
      int bad;
      bad = 0;
      while (init_busy === 1'b1 && n < 1000) begin
        if (pal_wr_ready !== 1'b0) bad++;
        if (n == 10) put_pix(8'h01, 1'b1, 1'b0, 24'h000055, "init_mode_forced_direct");
        else idle();
        n++;
        tick();
      end
      chk("init_cycles", 32'(n), 32'd256);
      chk("ready_low_in_init", 32'(bad), 32'd0);
    end
    idle();

    // Filled palette equals direct expansion
    put_pix(8'hC8, 1'b1, 1'b0, 24'hDB4900, "pal_C8"); tick();
    put_pix(8'hC8, 1'b0, 1'b0, 24'hDB4900, "dir_C8"); tick();

    // Direct sweep, plus hand-computed corner points
    for (int p = 0; p < 256; p++) begin
      put_pix(8'(p), 1'b0, 1'b0, direct(8'(p)), "sweep"); tick();
    end
    put_pix(8'hFF, 1'b0, 1'b0, 24'hFFFFFF, "dir_FF"); tick();
    put_pix(8'h01, 1'b0, 1'b0, 24'h000055, "dir_01"); tick();
    put_pix(8'h20, 1'b0, 1'b0, 24'h240000, "dir_20"); tick();

    // Per-pixel mode switching, back to back
    put_pix(8'h20, 1'b1, 1'b0, 24'h240000, "mix_pal_20"); tick();
    put_pix(8'hE3, 1'b0, 1'b0, 24'hFF00FF, "mix_dir_E3"); tick();
    put_pix(8'h1C, 1'b1, 1'b0, 24'h00FF00, "mix_pal_1C"); tick();
    idle();

    // Ready level in RUN with no blanking
    #1;
`ifdef PALETTE_BLANK_WRITE_EN
    chk("run_ready_active_video", 32'(pal_wr_ready), 32'd0);
`else
    chk("run_ready_active_video", 32'(pal_wr_ready), 32'd1);
`endif

    // Write then lookup the following cycle
    pal_write(8'h05, 24'h123456);
    put_pix(8'h05, 1'b1, 1'b0, 24'h123456, "wr_then_read"); tick();
    idle();

`ifndef PALETTE_BLANK_WRITE_EN
    // Same-cycle write and lookup: read-first
    pal_write(8'h05, 24'h000000);
    pal_wr_valid = 1'b1;
    pal_wr_addr  = 8'h05;
    pal_wr_data  = 24'hABCDEF;
    put_pix(8'h05, 1'b1, 1'b0, 24'h000000, "same_cycle_old"); tick();
    pal_wr_valid = 1'b0;
    put_pix(8'h05, 1'b1, 1'b0, 24'hABCDEF, "same_cycle_new"); tick();
    idle();
`else
    // A held write is refused during active video, accepted on first blank.
    pal_wr_valid = 1'b1;
    pal_wr_addr  = 8'h07;
    pal_wr_data  = 24'h0A0B0C;
    for (int i = 0; i < 3; i++) begin
      put_pix(8'h07, 1'b1, 1'b0, 24'h0024FF, "held_wr_old");
      #1;
      chk("held_wr_ready_low", 32'(pal_wr_ready), 32'd0);
      tick();
    end
    put_pix(8'h07, 1'b1, 1'b1, 24'h000000, "held_wr_blank");
    #1;
    chk("held_wr_ready_blank", 32'(pal_wr_ready), 32'd1);
    tick();
    pal_wr_valid = 1'b0;
    put_pix(8'h07, 1'b1, 1'b0, 24'h0A0B0C, "held_wr_new"); tick();
    idle();
`endif

    // Blanking forces black in both modes
    put_pix(8'hFF, 1'b0, 1'b1, 24'h000000, "blank_direct"); tick();
    put_pix(8'hFF, 1'b1, 1'b1, 24'h000000, "blank_palette"); tick();
    idle();
    tick(); tick(); tick();
    chk("drained_before_reset", 32'(sb.size()), 32'd0);

    // Reset discards an in-flight pixel
    pal_write(8'h05, 24'hABCDEF);
    pixel = 8'hFF; pix_valid = 1'b1; mode = 1'b0; pix_blank = 1'b0;
    tick();
    idle();
    Reset_n = 1'b0;
    tick();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_rgb", 32'({Red, Green, Blue}), 32'h0);
    tick();
    Reset_n = 1'b1;

    // Reset again at fill count 100
    for (int i = 0; i < 100; i++) tick();
    chk("mid_init_busy", 32'(init_busy), 32'd1);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    wait_init("restart", n);

    // Entry 5 holds its direct value again; other entries fully refilled
    put_pix(8'h05, 1'b1, 1'b0, 24'h002455, "refill_05"); tick();
    put_pix(8'hC8, 1'b1, 1'b0, 24'hDB4900, "refill_C8"); tick();
    put_pix(8'hFF, 1'b1, 1'b0, 24'hFFFFFF, "refill_FF"); tick();
    idle();
    tick(); tick(); tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
